// File: rtl/fetch_pc_sequencer.sv
// Fetch-address sequencer: walks the PC linearly or along predicted targets,
// redirects on ALU-reported mispredictions and holds a timed flush window after each one.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_1000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        icache_ready_i,
    input  logic        stall_i,
    input  logic        bp_prediction_i,
    input  logic        bp_taken_i,
    input  logic [31:0] bp_pred_pc_i,
    input  logic        bp_error_i,
    input  logic        alu_jumps_i,
    input  logic [31:0] alu_target_pc_i,
    input  logic [31:0] alu_branch_pc_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [15:0] mispredict_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    logic [31:0] seq_pc;
    logic [31:0] redirect_pc;
    logic        fetch_accepted;
    logic        predict_taken;

    assign seq_pc         = (pc_q + 32'd4) & ALIGN_MASK;
    assign redirect_pc    = (alu_jumps_i ? alu_target_pc_i : (alu_branch_pc_i + 32'd4)) & ALIGN_MASK;
    assign fetch_accepted = icache_ready_i & ~stall_i;
    assign predict_taken  = bp_prediction_i & bp_taken_i;

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pc_valid_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            flush_cnt_q   <= 3'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            flush_cnt_q   <= flush_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = pc_valid_q;
        flush_d       = flush_q;
        redirect_d    = 1'b0;
        flush_cnt_d   = flush_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d    = ST_FETCH;
                pc_d       = RESET_PC;
                pc_valid_d = 1'b1;
                flush_d    = 1'b0;
            end

            ST_FETCH: begin
                pc_valid_d = 1'b1;
                flush_d    = 1'b0;
                // A misprediction wins over stall, cache backpressure and the predictor.
                if (bp_error_i) begin
                    state_d     = ST_FLUSH;
                    pc_d        = redirect_pc;
                    pc_valid_d  = 1'b0;
                    flush_d     = 1'b1;
                    redirect_d  = 1'b1;
                    flush_cnt_d = FLUSH_LOAD;
                    if (mispred_cnt_q != CNT_MAX) begin
                        mispred_cnt_d = mispred_cnt_q + 16'd1;
                    end
                end else if (fetch_accepted) begin
                    pc_d = predict_taken ? (bp_pred_pc_i & ALIGN_MASK) : seq_pc;
                end
            end

            ST_FLUSH: begin
                pc_valid_d = 1'b0;
                flush_d    = 1'b1;
                // Last flush cycle: resume fetching at the held redirect target.
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_FETCH;
                    flush_cnt_d = 3'd0;
                    flush_d     = 1'b0;
                    pc_valid_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d    = ST_BOOT;
                pc_valid_d = 1'b0;
                flush_d    = 1'b0;
            end
        endcase
    end

    assign pc_o             = pc_q;
    assign pc_valid_o       = pc_valid_q;
    assign flush_o          = flush_q;
    assign redirect_o       = redirect_q;
    assign mispredict_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vector table, saturation sequence, then
// randomized traffic checked against a cycle-level behavioural model.
module tb_fetch_pc_sequencer;

    localparam logic [31:0] RESET_PC     = 32'h0000_1000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        icache_ready_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        bp_prediction_i = 1'b0;
    logic        bp_taken_i = 1'b0;
    logic [31:0] bp_pred_pc_i = 32'd0;
    logic        bp_error_i = 1'b0;
    logic        alu_jumps_i = 1'b0;
    logic [31:0] alu_target_pc_i = 32'd0;
    logic [31:0] alu_branch_pc_i = 32'd0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        redirect_o;
    logic [15:0] mispredict_cnt_o;

    fetch_pc_sequencer #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_i            (clk_i),
        .rsn_i            (rsn_i),
        .icache_ready_i   (icache_ready_i),
        .stall_i          (stall_i),
        .bp_prediction_i  (bp_prediction_i),
        .bp_taken_i       (bp_taken_i),
        .bp_pred_pc_i     (bp_pred_pc_i),
        .bp_error_i       (bp_error_i),
        .alu_jumps_i      (alu_jumps_i),
        .alu_target_pc_i  (alu_target_pc_i),
        .alu_branch_pc_i  (alu_branch_pc_i),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o),
        .flush_o          (flush_o),
        .redirect_o       (redirect_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: booting flag, remaining flush cycles, PC, redirect count.
    bit          m_boot = 1'b1;
    int          m_flush_left = 0;
    logic [31:0] m_pc = RESET_PC;
    bit          m_redir = 1'b0;
    int          m_cnt = 0;

    function automatic void model_step();
        logic [31:0] nxt;
        m_redir = 1'b0;
        if (!rsn_i) begin
            m_boot = 1'b1;
            m_pc = RESET_PC;
            m_flush_left = 0;
            m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_pc = RESET_PC;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (bp_error_i) begin
            nxt = alu_jumps_i ? alu_target_pc_i : alu_branch_pc_i + 32'd4;
            m_pc = {nxt[31:2], 2'b00};
            m_flush_left = FLUSH_CYCLES;
            m_redir = 1'b1;
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else if (!stall_i && icache_ready_i) begin
            nxt = (bp_prediction_i && bp_taken_i) ? bp_pred_pc_i : m_pc + 32'd4;
            m_pc = {nxt[31:2], 2'b00};
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " pc"}, pc_o, m_pc);
        chk({tag, " valid"}, 32'(pc_valid_o), 32'(!m_boot && m_flush_left == 0));
        chk({tag, " flush"}, 32'(flush_o), 32'(m_flush_left > 0));
        chk({tag, " redirect"}, 32'(redirect_o), 32'(m_redir));
        chk({tag, " cnt"}, 32'(mispredict_cnt_o), 32'(m_cnt));
    endtask

    typedef struct {
        bit          rsn, rdy, stl, prd, tkn;
        logic [31:0] ppc;
        bit          err, jmp;
        logic [31:0] tgt, br;
        logic [31:0] e_pc;
        bit          e_v, e_f, e_r;
        logic [15:0] e_c;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // rsn rdy stl prd tkn ppc  err jmp tgt br  | pc v f r cnt
        tbl.push_back('{0,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h1000,    0,0,0,16'd0});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h1000,    1,0,0,16'd0});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h1004,    1,0,0,16'd0});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h1008,    1,0,0,16'd0});
        tbl.push_back('{1,1,0,1,1,32'h2002,      0,0,32'h0,   32'h0,        32'h2000,    1,0,0,16'd0});
        tbl.push_back('{1,1,0,1,0,32'h2002,      0,0,32'h0,   32'h0,        32'h2004,    1,0,0,16'd0});
        tbl.push_back('{1,1,0,0,1,32'h5000,      0,0,32'h0,   32'h0,        32'h2008,    1,0,0,16'd0});
        tbl.push_back('{1,1,1,1,1,32'h6000,      0,0,32'h0,   32'h0,        32'h2008,    1,0,0,16'd0});
        tbl.push_back('{1,0,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h2008,    1,0,0,16'd0});
        tbl.push_back('{1,0,1,1,1,32'h6000,      1,0,32'h9000,32'h3000,     32'h3004,    0,1,1,16'd1});
        tbl.push_back('{1,1,0,1,1,32'h6000,      1,1,32'h7000,32'h7000,     32'h3004,    0,1,0,16'd1});
        tbl.push_back('{1,1,0,0,0,32'h0,         1,1,32'h8000,32'h0,        32'h3004,    1,0,0,16'd1});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h3008,    1,0,0,16'd1});
        tbl.push_back('{1,1,0,0,0,32'h0,         1,1,32'h4003,32'h0,        32'h4000,    0,1,1,16'd2});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h4000,    0,1,0,16'd2});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h4000,    1,0,0,16'd2});
        tbl.push_back('{1,1,0,1,1,32'hFFFF_FFFE, 0,0,32'h0,   32'h0,        32'hFFFF_FFFC,1,0,0,16'd2});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h0,       1,0,0,16'd2});
        tbl.push_back('{1,0,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h0,       1,0,0,16'd2});
        tbl.push_back('{1,0,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h0,       1,0,0,16'd2});
        tbl.push_back('{1,0,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h0,       1,0,0,16'd2});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h4,       1,0,0,16'd2});
        tbl.push_back('{1,1,0,0,0,32'h0,         1,0,32'h0,   32'hFFFF_FFFC,32'h0,       0,1,1,16'd3});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h0,       0,1,0,16'd3});
        tbl.push_back('{0,1,0,0,0,32'h0,         1,1,32'h9000,32'h0,        32'h1000,    0,0,0,16'd0});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h1000,    1,0,0,16'd0});
        tbl.push_back('{1,1,0,0,0,32'h0,         0,0,32'h0,   32'h0,        32'h1004,    1,0,0,16'd0});

        #2;
        foreach (tbl[i]) begin
            rsn_i = tbl[i].rsn;          icache_ready_i = tbl[i].rdy;
            stall_i = tbl[i].stl;        bp_prediction_i = tbl[i].prd;
            bp_taken_i = tbl[i].tkn;     bp_pred_pc_i = tbl[i].ppc;
            bp_error_i = tbl[i].err;     alu_jumps_i = tbl[i].jmp;
            alu_target_pc_i = tbl[i].tgt; alu_branch_pc_i = tbl[i].br;
            tick();
            chk($sformatf("vec%0d pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("vec%0d valid", i), 32'(pc_valid_o), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d flush", i), 32'(flush_o), 32'(tbl[i].e_f));
            chk($sformatf("vec%0d redirect", i), 32'(redirect_o), 32'(tbl[i].e_r));
            chk($sformatf("vec%0d cnt", i), 32'(mispredict_cnt_o), 32'(tbl[i].e_c));
        end

        // Saturation: preload the redirect count just below its ceiling.
        bp_error_i = 1'b0;
        force dut.mispred_cnt_q = 16'hFFFE;
        #1;
        release dut.mispred_cnt_q;
        m_cnt = 32'hFFFE;
        bp_error_i = 1'b1; alu_jumps_i = 1'b1; alu_target_pc_i = 32'h5000;
        tick();
        chk("sat1 cnt", 32'(mispredict_cnt_o), 32'hFFFF);
        chk("sat1 redirect", 32'(redirect_o), 32'd1);
        chk("sat1 pc", pc_o, 32'h5000);
        bp_error_i = 1'b0;
        tick();
        chk("sat flush2", 32'(flush_o), 32'd1);
        tick();
        chk("sat flush end", 32'(flush_o), 32'd0);
        chk("sat resume valid", 32'(pc_valid_o), 32'd1);
        bp_error_i = 1'b1; alu_jumps_i = 1'b0; alu_branch_pc_i = 32'h6000;
        tick();
        chk("sat2 cnt", 32'(mispredict_cnt_o), 32'hFFFF);
        chk("sat2 pc", pc_o, 32'h6004);
        bp_error_i = 1'b0;
        tick();
        tick();
        chk_model("sat model");

        // Randomized traffic against the behavioural model.
        for (int c = 0; c < 3000; c++) begin
            rsn_i           = ($urandom_range(0, 99) != 0);
            icache_ready_i  = ($urandom_range(0, 3) != 0);
            stall_i         = ($urandom_range(0, 4) == 0);
            bp_prediction_i = 1'($urandom);
            bp_taken_i      = 1'($urandom);
            bp_pred_pc_i    = $urandom;
            bp_error_i      = ($urandom_range(0, 7) == 0);
            alu_jumps_i     = 1'($urandom);
            alu_target_pc_i = $urandom;
            alu_branch_pc_i = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_1000, first fetch address after reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7, cycles flush_o stays high per redirect.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rsn_i  input  1  reset, synchronous, active-low.
REQ-005 icache_ready_i  input  1  fetch port accepts pc_o this cycle.
REQ-006 stall_i  input  1  pipeline stall; hold fetch PC.
REQ-007 bp_prediction_i  input  1  predictor hit for current pc_o.
REQ-008 bp_taken_i  input  1  predictor taken for current pc_o.
REQ-009 bp_pred_pc_i  input  32  predicted target for current pc_o.
REQ-010 bp_error_i  input  1  ALU reports misprediction.
REQ-011 alu_jumps_i  input  1  resolved branch taken.
REQ-012 alu_target_pc_i  input  32  resolved branch target.
REQ-013 alu_branch_pc_i  input  32  address of resolved branch.
REQ-014 pc_o  output  32  current fetch address.
REQ-015 pc_valid_o  output  1  pc_o is a real fetch request.
REQ-016 flush_o  output  1  kill all in-flight instructions younger than the branch.
REQ-017 redirect_o  output  1  one-cycle pulse, redirect accepted.
REQ-018 mispredict_cnt_o  output  16  saturating misprediction count.

Function
REQ-019 SHALL implement states BOOT, FETCH, FLUSH, all outputs registered.
REQ-020 BOOT: pc_valid_o=0; next cycle SHALL enter FETCH with pc_o=RESET_PC.
REQ-021 FETCH: pc_valid_o=1; bp_* inputs SHALL be treated as describing the current pc_o.
REQ-022 FETCH, bp_error_i=1: next pc_o SHALL be alu_target_pc_i if alu_jumps_i else alu_branch_pc_i+4; state FLUSH; redirect_o=1 for one cycle; counter loaded with FLUSH_CYCLES.
REQ-023 bp_error_i SHALL take priority over stall_i, icache_ready_i and the predictor.
REQ-024 FETCH, no error, stall_i=1 or icache_ready_i=0: pc_o SHALL hold.
REQ-025 FETCH, no error, accepted: next pc_o SHALL be bp_pred_pc_i if bp_prediction_i & bp_taken_i, else pc_o+4.
REQ-026 All next-PC values SHALL have bits [1:0] forced to 2'b00.
REQ-027 pc_o+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-028 FLUSH: flush_o=1, pc_valid_o=0, pc_o holds the redirect target; counter decrements each cycle; at 1 -> FETCH. Exactly FLUSH_CYCLES cycles of flush_o per redirect.
REQ-029 FLUSH: bp_error_i, stall_i, predictor inputs SHALL be ignored (no retarget, no count).
REQ-030 mispredict_cnt_o SHALL increment by 1 per accepted redirect, saturating at 16'hFFFF.

Reset
REQ-031 rsn_i=0 at a rising edge SHALL force: state BOOT, pc_o=RESET_PC, pc_valid_o=0, flush_o=0, redirect_o=0, flush counter=0, mispredict_cnt_o=0.
REQ-032 Reset SHALL override all inputs in any state, including mid-FLUSH; no flush cycles remain afterward.

Verification
REQ-033 Release reset, icache_ready_i=1, no prediction -> one BOOT cycle, then pc_o 0x1000, 0x1004, 0x1008, pc_valid_o=1.
REQ-034 At pc_o=0x1008: bp_prediction_i=1, bp_taken_i=1, bp_pred_pc_i=0x2002 -> next pc_o=0x2000; with bp_taken_i=0 -> 0x100C.
REQ-035 bp_error_i=1, alu_jumps_i=0, alu_branch_pc_i=0x3000, stall_i=1 -> redirect_o pulse, pc_o=0x3004, flush_o high 2 cycles, then fetch resumes at 0x3004; mispredict_cnt_o=1.
REQ-036 bp_error_i pulsed during FLUSH -> ignored: pc_o, flush length and counter unchanged.
REQ-037 pc_o=0xFFFF_FFFC, no prediction, accepted -> pc_o=0x0000_0000; icache_ready_i=0 for 3 cycles -> pc_o held.
REQ-038 rsn_i=0 in second FLUSH cycle -> next cycle BOOT, flush_o=0, mispredict_cnt_o=0; counter preloaded to 0xFFFF then one more redirect -> stays 0xFFFF.
